// File: rtl/apb_burst_master_if.sv
// Command, write/read stream, status and APB3 signals of apb_burst_master, bundled in one interface.
// The master modport is the initiator's view; the slave modport is the view of whatever drives and checks it.
interface apb_burst_master_if #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              abort;
  logic              wr_valid;
  logic              wr_ready;
  logic [31:0]       wr_data;
  logic              rd_valid;
  logic [31:0]       rd_data;
  logic              busy;
  logic              done;
  logic              err;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [31:0]       PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, abort, wr_valid, wr_data,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, abort, wr_valid, wr_data,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_burst_master.sv
// APB3 burst initiator: one command -> cmd_len single transfers; first read word 3 cycles after accept plus wait states.
// Write stream stalls via wr_ready, read stream has no backpressure; APB_TIMEOUT_EN adds an ACCESS-phase timeout.
module apb_burst_master #(
  parameter int ADDR_W      = 10,
  parameter int LEN_W       = 8,
  parameter int ADDR_STEP   = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input logic PCLK,
  input logic PRESERN,
  apb_burst_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              write_q, write_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q, err_d;
  logic              cmd_ready_q, busy_q, wr_ready_q, psel_q, penable_q, done_q;

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    write_d    = write_q;
    pwdata_d   = pwdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = err_q;
`ifdef APB_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          rem_d   = bus.cmd_len;
          write_d = bus.cmd_write;
          err_d   = 1'b0;
          if (bus.cmd_len == '0)  state_d = DONE;
          else if (bus.cmd_write) state_d = WDATA;
          else                    state_d = SETUP;
        end
      end
      WDATA: begin
        if (bus.abort) begin
          state_d = DONE;
        end else if (bus.wr_valid) begin
          pwdata_d = bus.wr_data;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = bus.abort ? DONE : ACCESS;
      ACCESS: begin
        // The phase only ends on PREADY; abort is looked at solely at that boundary.
        if (bus.PREADY) begin
          if (!write_q) begin
            rd_data_d  = bus.PRDATA;
            rd_valid_d = 1'b1;
          end
          err_d  = err_q | bus.PSLVERR;
          rem_d  = rem_q - LEN_W'(1);
          addr_d = addr_q + ADDR_W'(ADDR_STEP);
          if (rem_d == '0 || bus.abort) state_d = DONE;
          else if (write_q)             state_d = WDATA;
          else                          state_d = SETUP;
        end
`ifdef APB_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef APB_TIMEOUT_EN
    if (state_d == ACCESS && state_q != ACCESS) tmo_d = '0;
`endif
  end

  // Bus controls are registered from the next state so they change cleanly on the edge.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      write_q     <= 1'b0;
      pwdata_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      wr_ready_q  <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      done_q      <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      write_q     <= write_d;
      pwdata_q    <= pwdata_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      err_q       <= err_d;
      cmd_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      wr_ready_q  <= (state_d == WDATA);
      psel_q      <= (state_d == SETUP) || (state_d == ACCESS);
      penable_q   <= (state_d == ACCESS);
      done_q      <= (state_d == DONE);
`ifdef APB_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = write_q;
  assign bus.PADDR     = {{(32-ADDR_W){1'b0}}, addr_q};
  assign bus.PWDATA    = pwdata_q;
endmodule

// File: tb/tb_apb_burst_master.sv
// Directed bench for apb_burst_master: the initial block plays both the command source and the APB slave.
module tb_apb_burst_master;
  logic PCLK;
  logic PRESERN;
  int   total = 0;
  int   bad   = 0;

  apb_burst_master_if #(.ADDR_W(10), .LEN_W(8)) bif ();

  apb_burst_master dut (
    .PCLK    (PCLK),
    .PRESERN (PRESERN),
    .bus     (bif)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered with the DUT in SETUP; returns one cycle after PREADY was sampled.
  task automatic apb_xfer(input string tag, input logic [31:0] a, input logic w,
                          input logic [31:0] wd, input int waits,
                          input logic [31:0] rd, input logic se);
    chk($sformatf("%s.setup_psel", tag), bif.PSEL, 1);
    chk($sformatf("%s.setup_penable", tag), bif.PENABLE, 0);
    chk($sformatf("%s.paddr", tag), bif.PADDR, a);
    chk($sformatf("%s.pwrite", tag), bif.PWRITE, w);
    chk($sformatf("%s.done_low", tag), bif.done, 0);
    if (w) chk($sformatf("%s.pwdata", tag), bif.PWDATA, wd);
    tick();
    for (int k = 0; k < waits; k++) begin
      chk($sformatf("%s.wait%0d_psel", tag, k), bif.PSEL, 1);
      chk($sformatf("%s.wait%0d_penable", tag, k), bif.PENABLE, 1);
      chk($sformatf("%s.wait%0d_paddr", tag, k), bif.PADDR, a);
      tick();
    end
    chk($sformatf("%s.access_penable", tag), bif.PENABLE, 1);
    chk($sformatf("%s.access_paddr", tag), bif.PADDR, a);
    chk($sformatf("%s.rd_valid_low", tag), bif.rd_valid, 0);
    bif.PREADY  = 1'b1;
    bif.PRDATA  = rd;
    bif.PSLVERR = se;
    tick();
    bif.PREADY  = 1'b0;
    bif.PSLVERR = 1'b0;
    bif.PRDATA  = $urandom;
    if (!w) begin
      chk($sformatf("%s.rd_valid", tag), bif.rd_valid, 1);
      chk($sformatf("%s.rd_data", tag), bif.rd_data, rd);
    end
  endtask

  task automatic send_cmd(input logic w, input logic [9:0] a, input logic [7:0] len);
    bif.cmd_valid = 1'b1;
    bif.cmd_write = w;
    bif.cmd_addr  = a;
    bif.cmd_len   = len;
    tick();
    bif.cmd_valid = 1'b0;
  endtask

  initial begin
    bif.cmd_valid = 1'b0;
    bif.cmd_write = 1'b0;
    bif.cmd_addr  = '0;
    bif.cmd_len   = '0;
    bif.abort     = 1'b0;
    bif.wr_valid  = 1'b0;
    bif.wr_data   = '0;
    bif.PRDATA    = '0;
    bif.PREADY    = 1'b0;
    bif.PSLVERR   = 1'b0;
    PRESERN       = 1'b0;
    #12;
    chk("rst.cmd_ready", bif.cmd_ready, 1);
    chk("rst.busy", bif.busy, 0);
    chk("rst.psel", bif.PSEL, 0);
    chk("rst.penable", bif.PENABLE, 0);
    chk("rst.paddr", bif.PADDR, 0);
    chk("rst.done", bif.done, 0);
    chk("rst.err", bif.err, 0);
    chk("rst.rd_valid", bif.rd_valid, 0);
    chk("rst.wr_ready", bif.wr_ready, 0);
    PRESERN = 1'b1;
    tick();

    // Read burst wrapping the 10-bit address, two wait states per transfer.
    send_cmd(1'b0, 10'h3FE, 8'd4);
    chk("rd.busy", bif.busy, 1);
    chk("rd.cmd_ready", bif.cmd_ready, 0);
    apb_xfer("rd0", 32'h3FE, 1'b0, 32'h0, 2, 32'hA0A0_0001, 1'b0);
    apb_xfer("rd1", 32'h3FF, 1'b0, 32'h0, 2, 32'hA0A0_0002, 1'b0);
    apb_xfer("rd2", 32'h000, 1'b0, 32'h0, 2, 32'hA0A0_0003, 1'b0);
    apb_xfer("rd3", 32'h001, 1'b0, 32'h0, 2, 32'hA0A0_0004, 1'b0);
    chk("rd.done", bif.done, 1);
    chk("rd.psel_end", bif.PSEL, 0);
    tick();
    chk("rd.done_once", bif.done, 0);
    chk("rd.idle_ready", bif.cmd_ready, 1);
    chk("rd.rd_valid_pulse", bif.rd_valid, 0);
    chk("rd.rd_data_held", bif.rd_data, 32'hA0A0_0004);

    // Write burst with 5-cycle stream gaps; a second command during the burst is ignored.
    bif.cmd_valid = 1'b1;
    bif.cmd_write = 1'b1;
    bif.cmd_addr  = 10'h010;
    bif.cmd_len   = 8'd3;
    tick();
    bif.cmd_len   = 8'd0;
    bif.cmd_addr  = 10'h2AA;
    for (int i = 0; i < 3; i++) begin
      for (int g = 0; g < 5; g++) begin
        chk($sformatf("wr%0d.gap_wr_ready", i), bif.wr_ready, 1);
        chk($sformatf("wr%0d.gap_psel", i), bif.PSEL, 0);
        tick();
      end
      bif.cmd_valid = 1'b0;
      bif.wr_valid  = 1'b1;
      bif.wr_data   = 32'hC0DE_0000 + i;
      tick();
      bif.wr_valid  = 1'b0;
      chk($sformatf("wr%0d.wr_ready_low", i), bif.wr_ready, 0);
      apb_xfer($sformatf("wr%0d", i), 32'h010 + i, 1'b1, 32'hC0DE_0000 + i, i, 32'h0, 1'b0);
    end
    chk("wr.done", bif.done, 1);
    chk("wr.err", bif.err, 0);
    tick();

    // PSLVERR on the middle read: burst continues, err sticks.
    send_cmd(1'b0, 10'h100, 8'd3);
    apb_xfer("se0", 32'h100, 1'b0, 32'h0, 0, 32'h0000_0011, 1'b0);
    chk("se0.err", bif.err, 0);
    apb_xfer("se1", 32'h101, 1'b0, 32'h0, 1, 32'h0000_0022, 1'b1);
    chk("se1.err", bif.err, 1);
    apb_xfer("se2", 32'h102, 1'b0, 32'h0, 0, 32'h0000_0033, 1'b0);
    chk("se2.done", bif.done, 1);
    chk("se2.err", bif.err, 1);
    tick();
    chk("se.err_idle", bif.err, 1);

    // Empty command: done one cycle after accept, no APB activity, err cleared.
    send_cmd(1'b1, 10'h055, 8'd0);
    chk("len0.done", bif.done, 1);
    chk("len0.psel", bif.PSEL, 0);
    chk("len0.err_clr", bif.err, 0);
    chk("len0.wr_ready", bif.wr_ready, 0);
    tick();
    chk("len0.done_low", bif.done, 0);
    chk("len0.cmd_ready", bif.cmd_ready, 1);
    chk("len0.psel_idle", bif.PSEL, 0);

    // Abort during the second ACCESS wait of a 5-word write.
    send_cmd(1'b1, 10'h020, 8'd5);
    bif.wr_valid = 1'b1;
    bif.wr_data  = 32'h1111_0000;
    tick();
    bif.wr_valid = 1'b0;
    apb_xfer("ab0", 32'h020, 1'b1, 32'h1111_0000, 0, 32'h0, 1'b0);
    bif.wr_valid = 1'b1;
    bif.wr_data  = 32'h2222_0000;
    tick();
    bif.wr_valid = 1'b0;
    chk("ab1.setup_psel", bif.PSEL, 1);
    chk("ab1.paddr", bif.PADDR, 32'h021);
    tick();
    chk("ab1.wait0_penable", bif.PENABLE, 1);
    tick();
    bif.abort = 1'b1;
    chk("ab1.wait1_penable", bif.PENABLE, 1);
    tick();
    chk("ab1.wait2_penable", bif.PENABLE, 1);
    chk("ab1.wait2_psel", bif.PSEL, 1);
    bif.PREADY = 1'b1;
    tick();
    bif.PREADY = 1'b0;
    chk("ab.done", bif.done, 1);
    chk("ab.psel", bif.PSEL, 0);
    chk("ab.wr_ready", bif.wr_ready, 0);
    tick();
    chk("ab.psel_after", bif.PSEL, 0);
    chk("ab.cmd_ready", bif.cmd_ready, 1);
    chk("ab.done_low", bif.done, 0);
    tick();
    bif.abort = 1'b0;
    chk("ab.no_setup", bif.PSEL, 0);
    chk("ab.idle_busy", bif.busy, 0);

    // Asynchronous reset in the middle of an ACCESS phase.
    send_cmd(1'b0, 10'h055, 8'd2);
    tick();
    chk("arst.in_access", bif.PENABLE, 1);
    PRESERN = 1'b0;
    #1;
    chk("arst.psel", bif.PSEL, 0);
    chk("arst.penable", bif.PENABLE, 0);
    chk("arst.busy", bif.busy, 0);
    chk("arst.cmd_ready", bif.cmd_ready, 1);
    chk("arst.paddr", bif.PADDR, 0);
    #3;
    PRESERN = 1'b1;
    tick();
    chk("arst.stay_idle", bif.busy, 0);

`ifdef APB_TIMEOUT_EN
    // PREADY never arrives: 64 ACCESS cycles, then forced end with err.
    send_cmd(1'b0, 10'h200, 8'd1);
    chk("tmo.setup", bif.PSEL, 1);
    tick();
    for (int c = 0; c < 64; c++) begin
      chk($sformatf("tmo.access%0d", c), bif.PENABLE, 1);
      tick();
    end
    chk("tmo.psel", bif.PSEL, 0);
    chk("tmo.penable", bif.PENABLE, 0);
    chk("tmo.done", bif.done, 1);
    chk("tmo.err", bif.err, 1);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
